// File: rtl/sprite_anim_sequencer.sv
// ---------------------------------------------------------------------------
// sprite_anim_sequencer
//
// Picks the sprite ROM/palette entry for a top-down hero. It cycles a
// two-frame walk, plays a four-frame sword swing, and then enforces a short
// cooldown before the hero can walk or swing again. All timing is counted
// in frame_tick pulses (one per vsync).
//
// Optional feature: define ATTACK_BUFFER_EN to remember one attack_req that
// arrives during ATTACK or COOLDOWN. The remembered request starts a new
// swing as soon as COOLDOWN ends.
//
// Parameters
//   FRAME_TICKS     frame_tick pulses per animation frame (1..15)
//   COOLDOWN_TICKS  frame_tick pulses spent in COOLDOWN   (1..15)
//
// Ports
//   Clk          system clock; all state changes happen on its rising edge
//   Reset        asynchronous, active-high reset
//   frame_tick   one-cycle pulse per vsync
//   dir          requested direction: 0 up, 1 down, 2 left, 3 right
//   moving       high while a movement key is held
//   attack_req   level request for a sword swing
//   sprite_sel   {kind, facing[1:0], frame[1:0]}; kind 1 = sword ROM
//   facing       latched facing direction
//   attack_busy  high while the state is ATTACK or COOLDOWN (registered)
//   attack_done  one-cycle pulse after the last sword frame ends
//   o_dbg_state  current FSM state: 0 IDLE, 1 WALK, 2 ATTACK, 3 COOLDOWN
//
// Handshake: there is no valid/ready pair. sprite_sel, attack_busy and
// attack_done are registered from the state held before each rising edge,
// so they show a new state one cycle after the edge that entered it.
// ---------------------------------------------------------------------------
module sprite_anim_sequencer #(
    parameter int FRAME_TICKS    = 6,
    parameter int COOLDOWN_TICKS = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic [1:0] dir,
    input  logic       moving,
    input  logic       attack_req,
    output logic [4:0] sprite_sel,
    output logic [1:0] facing,
    output logic       attack_busy,
    output logic       attack_done,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WALK     = 2'd1,
        S_ATTACK   = 2'd2,
        S_COOLDOWN = 2'd3
    } state_t;

    localparam logic [3:0] FRAME_LAST = 4'(FRAME_TICKS - 1);
    localparam logic [3:0] COOL_LAST  = 4'(COOLDOWN_TICKS - 1);

    state_t     r_state, w_next_state;
    logic [3:0] r_tick, w_next_tick;
    logic [1:0] r_frame, w_next_frame;
    logic [1:0] r_facing, w_next_facing;
    logic       w_swing_end;
    logic [4:0] r_sprite_sel;
    logic       r_busy;
    logic       r_done;

`ifdef ATTACK_BUFFER_EN
    logic       r_buf, w_next_buf;
`endif

    // Next state, counters and facing.
    always_comb begin
        w_next_state  = r_state;
        w_next_tick   = r_tick;
        w_next_frame  = r_frame;
        w_next_facing = r_facing;
        w_swing_end   = 1'b0;
`ifdef ATTACK_BUFFER_EN
        w_next_buf    = r_buf;
`endif

        case (r_state)
            S_IDLE, S_WALK: begin
                w_next_facing = dir;
                // An attack wins over movement.
                if (attack_req)  w_next_state = S_ATTACK;
                else if (moving) w_next_state = S_WALK;
                else             w_next_state = S_IDLE;
            end
            S_ATTACK: begin
                if (frame_tick && r_tick == FRAME_LAST && r_frame == 2'd3) begin
                    w_next_state = S_COOLDOWN;
                    w_swing_end  = 1'b1;
                end
            end
            S_COOLDOWN: begin
                if (frame_tick && r_tick == COOL_LAST) begin
`ifdef ATTACK_BUFFER_EN
                    // A request arriving on the exit cycle itself is treated
                    // as latched and consumed at the same time.
                    if (r_buf || attack_req) w_next_state = S_ATTACK;
                    else if (moving)         w_next_state = S_WALK;
                    else                     w_next_state = S_IDLE;
`else
                    if (moving) w_next_state = S_WALK;
                    else        w_next_state = S_IDLE;
`endif
                end
            end
            default: w_next_state = S_IDLE;
        endcase

`ifdef ATTACK_BUFFER_EN
        if (r_state == S_COOLDOWN && w_next_state != S_COOLDOWN)
            w_next_buf = 1'b0;
        else if ((r_state == S_ATTACK || r_state == S_COOLDOWN) && attack_req)
            w_next_buf = 1'b1;
`endif

        // A state change restarts timing; a tick on that same cycle is dropped.
        if (w_next_state != r_state) begin
            w_next_tick  = 4'd0;
            w_next_frame = 2'd0;
        end else if (frame_tick) begin
            if (r_state == S_COOLDOWN) begin
                // Exit happens at COOL_LAST, so this never needs to wrap.
                w_next_tick = r_tick + 4'd1;
            end else if (r_tick == FRAME_LAST) begin
                w_next_tick = 4'd0;
                case (r_state)
                    S_WALK:   w_next_frame = {1'b0, ~r_frame[0]};
                    S_ATTACK: w_next_frame = r_frame + 2'd1;
                    default:  w_next_frame = 2'd0;
                endcase
            end else begin
                w_next_tick = r_tick + 4'd1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_tick       <= 4'd0;
            r_frame      <= 2'd0;
            r_facing     <= 2'd1;
            r_sprite_sel <= 5'b00100;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_tick       <= w_next_tick;
            r_frame      <= w_next_frame;
            r_facing     <= w_next_facing;
            // COOLDOWN shows the walk sheet at frame 0.
            r_sprite_sel <= {r_state == S_ATTACK, r_facing,
                             (r_state == S_COOLDOWN) ? 2'b00 : r_frame};
            r_busy       <= (r_state == S_ATTACK) || (r_state == S_COOLDOWN);
            r_done       <= w_swing_end;
        end
    end

`ifdef ATTACK_BUFFER_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) r_buf <= 1'b0;
        else       r_buf <= w_next_buf;
    end
`endif

    assign sprite_sel  = r_sprite_sel;
    assign facing      = r_facing;
    assign attack_busy = r_busy;
    assign attack_done = r_done;
    assign o_dbg_state = r_state;

endmodule

// File: doc/sprite_anim_sequencer.md
SPRITE_ANIM_SEQUENCER -- requirements
Module: sprite_anim_sequencer

Interface
REQ-001 SHALL have parameter FRAME_TICKS, default 6: frame_tick pulses per animation frame; legal range 1..15.
REQ-002 SHALL have parameter COOLDOWN_TICKS, default 4: frame_tick pulses spent in COOLDOWN; legal range 1..15.
REQ-003 SHALL have port Clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port frame_tick, input, 1 bit: one-cycle pulse per vsync.
REQ-006 SHALL have port dir, input, 2 bits: requested direction; 0 up, 1 down, 2 left, 3 right.
REQ-007 SHALL have port moving, input, 1 bit: 1 while a movement key is held.
REQ-008 SHALL have port attack_req, input, 1 bit: level request for a sword swing.
REQ-009 SHALL have port sprite_sel, output, 5 bits: {kind, facing[1:0], frame[1:0]}; kind 0 = walk ROM/palette pair, kind 1 = sword ROM/palette pair.
REQ-010 SHALL have port facing, output, 2 bits: latched facing direction.
REQ-011 SHALL have port attack_busy, output, 1 bit: high in ATTACK and COOLDOWN.
REQ-012 SHALL have port attack_done, output, 1 bit: one-cycle pulse when the last sword frame ends.

Function
REQ-013 SHALL implement states IDLE, WALK, ATTACK, COOLDOWN.
REQ-014 SHALL hold a tick counter of 4 bits; in IDLE, WALK and ATTACK it counts frame_tick pulses 0..FRAME_TICKS-1 and wraps to 0 ("frame wrap").
REQ-015 SHALL clear the tick counter and frame to 0 on every state change.
REQ-016 SHALL move IDLE->WALK when moving=1 and attack_req=0, and WALK->IDLE when moving=0 and attack_req=0.
REQ-017 SHALL toggle frame between 0 and 1 on each frame wrap in WALK, and hold frame at 0 in IDLE.
REQ-018 SHALL update facing from dir every cycle in IDLE and WALK, and freeze it in ATTACK and COOLDOWN.
REQ-019 SHALL move IDLE or WALK->ATTACK when attack_req=1; when attack_req and moving are both 1, the attack takes priority.
REQ-020 SHALL advance frame 0->1->2->3 on frame wraps in ATTACK; a frame wrap at frame 3 SHALL move to COOLDOWN and pulse attack_done for exactly that cycle.
REQ-021 SHALL count COOLDOWN_TICKS frame_tick pulses in COOLDOWN, then go to WALK if moving=1, else to IDLE.
REQ-022 SHALL register sprite_sel and attack_busy so that they reflect the new state one cycle after the transition edge; sprite_sel kind=1 only in ATTACK, and COOLDOWN shows walk frame 0.
REQ-023 SHALL ignore frame_tick pulses that coincide with a state change.
REQ-024 SHALL keep the swing length at exactly 4*FRAME_TICKS frame_tick pulses, independent of dir or moving changes mid-swing.

Reset
REQ-025 SHALL, while Reset=1 and regardless of Clk, force state IDLE, facing=1 (down), sprite_sel=5'b00100, tick counter 0, attack_busy 0, attack_done 0, and the attack buffer empty.
REQ-026 SHALL abandon an in-progress swing when Reset is asserted mid-ATTACK and SHALL NOT emit attack_done for it.

Configuration
REQ-027 SHALL, with ATTACK_BUFFER_EN defined, latch one attack_req seen during ATTACK or COOLDOWN into a one-deep buffer; on COOLDOWN exit the buffer SHALL send the block to ATTACK instead of IDLE/WALK, and SHALL then clear; further requests while the buffer is full SHALL be dropped.
REQ-028 SHALL, without ATTACK_BUFFER_EN, drop attack_req during ATTACK and COOLDOWN; an attack_req still high at COOLDOWN exit SHALL start a new swing only from IDLE/WALK on the following cycle.

Verification (FRAME_TICKS=2, COOLDOWN_TICKS=3)
REQ-029 SHALL cover: Reset pulse mid-WALK -> sprite_sel=5'b00100, facing=1, attack_busy=0 immediately, without a clock edge.
REQ-030 SHALL cover: moving=1, dir=3, 6 frame_ticks -> sprite_sel sequence 01100, 01101, 01100, 01101.
REQ-031 SHALL cover: attack_req=1 and moving=1 in the same cycle with dir=2 -> sprite_sel=11000; after 8 ticks, frames 0..3 shown, attack_done for one cycle, attack_busy held until 3 more ticks.
REQ-032 SHALL cover: dir changed 2->0 mid-swing -> facing stays 2 and sprite_sel[3:2]=10 throughout.
REQ-033 SHALL cover: attack_req pulsed during COOLDOWN -> with ATTACK_BUFFER_EN, second swing starts at COOLDOWN exit (sprite_sel kind=1); without it, the block returns to IDLE (sprite_sel=5'b01000 for dir=2).
REQ-034 SHALL cover: Reset asserted at sword frame 2 -> no attack_done pulse, state IDLE after release.
